// File: rtl/reg_dump_reader.sv
// Walks register indices FIRST_REG..LAST_REG through an async regfile read port and streams
// each word out over a valid/ready handshake, accumulating a 32-bit wrap-around checksum.
module reg_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  raddr,
  input  logic [31:0] rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

  localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
  localparam logic [4:0] LastIdx  = 5'(LAST_REG);

  state_e      r_state;
  logic [4:0]  r_idx;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [4:0]  r_out_idx;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_checksum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_checksum  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_idx      <= FirstIdx;
            r_checksum <= '0;
            r_busy     <= 1'b1;
            r_state    <= StFetch;
          end
        end
        StFetch: begin
          r_out_data  <= rdata;
          r_out_idx   <= r_idx;
          r_out_valid <= 1'b1;
          r_state     <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            r_checksum  <= r_checksum + r_out_data;
            r_out_valid <= 1'b0;
            // idx stops at LastIdx so it never wraps past the dump range
            if (r_idx == LastIdx) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_state <= StFetch;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign raddr     = r_idx;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign checksum  = r_checksum;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full dumps, backpressure, start spam, wrap-around
// checksums, mid-dump reset and a single-register instance.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic        start2 = 1'b0;
  logic        out_ready2 = 1'b0;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic [4:0]  out_idx2;
  logic        busy2;
  logic        done2;
  logic [31:0] checksum2;

  logic [31:0] regval [32];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rdata  = regval[raddr];
  assign rdata2 = regval[raddr2];

  reg_dump_reader u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  reg_dump_reader #(
    .FIRST_REG (5),
    .LAST_REG  (5)
  ) u_dut_one (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .raddr     (raddr2),
    .rdata     (rdata2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2),
    .out_idx   (out_idx2),
    .busy      (busy2),
    .done      (done2),
    .checksum  (checksum2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full 0..31 dump on u_dut; inputs change and outputs are sampled at negedge.
  task automatic do_dump(input int stall_idx, input int stall_len, input bit spam,
                         input logic [31:0] exp_sum);
    logic [31:0] run_sum;
    run_sum   = 32'h0;
    start     = 1'b1;
    @(negedge clk);
    start = spam;
    check("fetch_busy", {31'h0, busy}, 32'h1);
    check("fetch_valid", {31'h0, out_valid}, 32'h0);
    for (int k = 0; k < 32; k++) begin
      out_ready = (k == stall_idx) ? 1'b0 : 1'b1;
      @(negedge clk);
      check("send_valid", {31'h0, out_valid}, 32'h1);
      check("send_idx", {27'h0, out_idx}, k);
      check("send_data", out_data, regval[k]);
      if (k == stall_idx) begin
        repeat (stall_len) begin
          @(negedge clk);
          check("stall_valid", {31'h0, out_valid}, 32'h1);
          check("stall_idx", {27'h0, out_idx}, k);
          check("stall_data", out_data, regval[k]);
          check("stall_sum", checksum, run_sum);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      run_sum = run_sum + regval[k];
      check("run_sum", checksum, run_sum);
      check("post_valid", {31'h0, out_valid}, 32'h0);
      if (k < 31) begin
        check("mid_busy", {31'h0, busy}, 32'h1);
        check("mid_done", {31'h0, done}, 32'h0);
        check("mid_raddr", {27'h0, raddr}, k + 1);
      end else begin
        check("last_done", {31'h0, done}, 32'h1);
        check("last_busy", {31'h0, busy}, 32'h0);
        check("last_raddr", {27'h0, raddr}, 32'd31);
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("idle_done", {31'h0, done}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);
    check("final_sum", checksum, exp_sum);
    @(negedge clk);
    check("idle_hold_valid", {31'h0, out_valid}, 32'h0);
    check("idle_hold_sum", checksum, exp_sum);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regval[i] = i * 32'h0101;
    regval[5] = 32'h0000_0505;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_idx", {27'h0, out_idx}, 32'h0);
    check("rst_raddr", {27'h0, raddr}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_sum", checksum, 32'h0);

    // 257 * (1+..+31) = 127472
    do_dump(-1, 0, 1'b0, 32'h0001_F1F0);
    do_dump(3, 5, 1'b0, 32'h0001_F1F0);
    do_dump(-1, 0, 1'b1, 32'h0001_F1F0);

    // Previous checksum is non-zero, so the first running check proves it was cleared.
    for (int i = 0; i < 32; i++) regval[i] = 32'h8000_0000;
    do_dump(-1, 0, 1'b0, 32'h0);
    do_dump(-1, 0, 1'b0, 32'h0);

    for (int i = 0; i < 32; i++) regval[i] = i * 32'h0101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) repeat (2) @(negedge clk);
    @(negedge clk);
    check("pre_rst_idx", {27'h0, out_idx}, 32'd10);
    check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    rst       = 1'b1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_data", out_data, 32'h0);
    check("midrst_idx", {27'h0, out_idx}, 32'h0);
    check("midrst_raddr", {27'h0, raddr}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_sum", checksum, 32'h0);
    repeat (3) @(negedge clk);
    check("postrst_valid", {31'h0, out_valid}, 32'h0);
    check("postrst_busy", {31'h0, busy}, 32'h0);
    do_dump(-1, 0, 1'b0, 32'h0001_F1F0);

    regval[5] = 32'hFFFF_FFFF;
    check("one_raddr_rst", {27'h0, raddr2}, 32'h0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("one_raddr", {27'h0, raddr2}, 32'd5);
    check("one_busy", {31'h0, busy2}, 32'h1);
    @(negedge clk);
    check("one_valid", {31'h0, out_valid2}, 32'h1);
    check("one_idx", {27'h0, out_idx2}, 32'd5);
    check("one_data", out_data2, 32'hFFFF_FFFF);
    out_ready2 = 1'b1;
    @(negedge clk);
    check("one_done", {31'h0, done2}, 32'h1);
    check("one_sum", checksum2, 32'hFFFF_FFFF);
    check("one_raddr_end", {27'h0, raddr2}, 32'd5);
    @(negedge clk);
    check("one_done_off", {31'h0, done2}, 32'h0);
    check("one_valid_off", {31'h0, out_valid2}, 32'h0);
    check("one_busy_off", {31'h0, busy2}, 32'h0);
    check("one_sum_hold", checksum2, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
